// File: rtl/ram64_loader_pkg.sv
// rtl/ram64_loader_pkg.sv - shared sizes and loader FSM encodings for the ram64 family
//
// Purpose: single source for the ram64 geometry (word width, address width,
// depth) and the loader state encoding, imported by ram64_loader.
package ram64_loader_pkg;

  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/ram64_loader.sv
// rtl/ram64_loader.sv - streams handshaked words into consecutive ram64 addresses
//
// Purpose: preloads ram64 from an upstream valid/ready word stream, starting at
// a programmed base address and wrapping modulo DEPTH.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, base_addr, count  transfer request (sampled in IDLE only)
//   in_valid, in_data        upstream word; in_ready accepts it
//   ram_in, ram_address,     direct drive of ram64 in/address/load
//   ram_load
//   busy, done, err          status: in LOAD, 1-cycle finish pulse, sticky bad count
//   words_done               words written by the current/last transfer
module ram64_loader
  import ram64_loader_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_done
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic [ADDR_W:0]   r_words_done;
  logic              r_err;
  logic              r_err_done;

  logic w_idle;
  logic w_count_ok;
  logic w_xfer;
  logic w_last;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_count_ok = (count != '0) && (count <= (ADDR_W+1)'(DEPTH));
  assign w_xfer     = in_valid && (r_state == ST_LOAD);
  assign w_last     = w_xfer && (r_remain == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start && w_count_ok) w_next = ST_LOAD;
      ST_LOAD:   if (w_last) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_remain     <= '0;
      r_words_done <= '0;
      r_err        <= 1'b0;
      r_err_done   <= 1'b0;
    end else begin
      // A rejected start still owes the requester a done pulse, one cycle later.
      r_err_done <= 1'b0;
      if (w_idle && start) begin
        if (w_count_ok) begin
          r_addr       <= base_addr;
          r_remain     <= count;
          r_words_done <= '0;
          r_err        <= 1'b0;
        end else begin
          r_err      <= 1'b1;
          r_err_done <= 1'b1;
        end
      end else if (w_xfer) begin
        // DEPTH is 2**ADDR_W, so the natural overflow gives the modulo wrap.
        r_addr       <= r_addr + 1'b1;
        r_remain     <= r_remain - 1'b1;
        r_words_done <= r_words_done + 1'b1;
      end
    end
  end

  assign in_ready    = (r_state == ST_LOAD);
  assign busy        = (r_state == ST_LOAD);
  assign ram_load    = w_xfer;
  // Gate data so ram_in is a defined zero outside LOAD, including during reset.
  assign ram_in      = in_ready ? in_data : '0;
  assign ram_address = r_addr;
  assign done        = (r_state == ST_FINISH) || r_err_done;
  assign err         = r_err;
  assign words_done  = r_words_done;

endmodule
